// File: rtl/deadlock_stall_detector_if.sv
// Status/result bundle between the kernel monitor top and the deadlock stall detector.
// master drives the per-kernel status vectors; slave (the detector) returns the verdict.
interface deadlock_stall_detector_if #(
  parameter int N_AXIS = 1,
  parameter int N_INST = 5,
  parameter int N_BLK  = 3,
  parameter int IDX_W  = ($clog2(N_BLK) > 0) ? $clog2(N_BLK) : 1
);
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_BLK-1:0]  inst_block_sigs;
  logic              block;
  logic [N_BLK-1:0]  blk_inst_mask;
  logic [N_AXIS-1:0] blk_axis_mask;
  logic [IDX_W-1:0]  first_blk_idx;
  logic              first_blk_vld;
  logic [31:0]       stall_cycles;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  block, blk_inst_mask, blk_axis_mask, first_blk_idx, first_blk_vld, stall_cycles
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output block, blk_inst_mask, blk_axis_mask, first_blk_idx, first_blk_vld, stall_cycles
  );
endinterface

// File: rtl/deadlock_stall_detector.sv
// Declares a kernel deadlock after HOLD_CYCLES consecutive all-idle-or-blocked cycles and
// snapshots the blockers. Define DEADLOCK_STALL_RELEASE_EN to let BLOCKED fall back to MON.
module deadlock_stall_detector #(
  parameter int N_AXIS      = 1,
  parameter int N_INST      = 5,
  parameter int N_BLK       = 3,
  parameter int HOLD_CYCLES = 16
) (
  input logic clock,
  input logic reset,
  deadlock_stall_detector_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = ($clog2(N_BLK) > 0) ? $clog2(N_BLK) : 1;

  typedef enum logic [1:0] {MON, CNT, BLOCKED} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              block_q;
  logic [N_BLK-1:0]  inst_mask_q;
  logic [N_AXIS-1:0] axis_mask_q;
  logic [IDX_W-1:0]  idx_q;
  logic              vld_q;
  logic [31:0]       stall_q;

  logic [N_INST-1:0] stalled;
  logic              cand;
  logic              hit;
  logic [IDX_W-1:0]  lo_idx;

  // Instances without a block line can only count as stalled by being idle.
  for (genvar i = 0; i < N_INST; i++) begin : g_stall
    if (i < N_BLK) begin : g_pair
      assign stalled[i] = bus.inst_idle_sigs[i] | bus.inst_block_sigs[i];
    end else begin : g_idle
      assign stalled[i] = bus.inst_idle_sigs[i];
    end
  end

  // All-idle means the kernel finished, so it never counts as a deadlock.
  assign cand = (&stalled) & ((|bus.inst_block_sigs) | (|bus.axis_block_sigs))
              & ~(&bus.inst_idle_sigs);

  assign hit = cand & (((state == MON) && (HOLD_CYCLES == 1)) ||
                       ((state == CNT) && (cnt == CNT_W'(HOLD_CYCLES - 1))));

  always_comb begin
    lo_idx = '0;
    for (int i = N_BLK - 1; i >= 0; i--)
      if (bus.inst_block_sigs[i]) lo_idx = IDX_W'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= MON;
      cnt         <= '0;
      block_q     <= 1'b0;
      inst_mask_q <= '0;
      axis_mask_q <= '0;
      idx_q       <= '0;
      vld_q       <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (!cand)               stall_q <= '0;
      else if (stall_q != '1)  stall_q <= stall_q + 32'd1;

      case (state)
        MON: begin
          if (cand) begin
            if (HOLD_CYCLES == 1) state <= BLOCKED;
            else begin
              state <= CNT;
              cnt   <= CNT_W'(1);
            end
          end
        end
        CNT: begin
          if (!cand) begin
            state <= MON;
            cnt   <= '0;
          end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state <= BLOCKED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLOCKED: begin
`ifdef DEADLOCK_STALL_RELEASE_EN
          // Masks stay as the last snapshot; only the block line drops.
          if (!cand) begin
            state   <= MON;
            block_q <= 1'b0;
          end
`endif
        end
        default: begin
          state <= MON;
          cnt   <= '0;
        end
      endcase

      if (hit) begin
        block_q     <= 1'b1;
        inst_mask_q <= bus.inst_block_sigs;
        axis_mask_q <= bus.axis_block_sigs;
        idx_q       <= lo_idx;
        vld_q       <= |bus.inst_block_sigs;
      end
    end
  end

  assign bus.block         = block_q;
  assign bus.blk_inst_mask = inst_mask_q;
  assign bus.blk_axis_mask = axis_mask_q;
  assign bus.first_blk_idx = idx_q;
  assign bus.first_blk_vld = vld_q;
  assign bus.stall_cycles  = stall_q;
endmodule

// File: tb/tb_deadlock_stall_detector.sv
// Directed bench: u0 uses default parameters, u1 uses HOLD_CYCLES=1 with its own reset.
module tb_deadlock_stall_detector;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rst1  = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  deadlock_stall_detector_if #(.N_AXIS(1), .N_INST(5), .N_BLK(3)) bus0 ();
  deadlock_stall_detector_if #(.N_AXIS(1), .N_INST(5), .N_BLK(3)) bus1 ();

  deadlock_stall_detector #(.N_AXIS(1), .N_INST(5), .N_BLK(3), .HOLD_CYCLES(16)) u0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  deadlock_stall_detector #(.N_AXIS(1), .N_INST(5), .N_BLK(3), .HOLD_CYCLES(1)) u1 (
    .clock(clock), .reset(rst1), .bus(bus1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic axis, input logic [4:0] idle, input logic [2:0] blk);
    bus0.axis_block_sigs = axis;
    bus0.inst_idle_sigs  = idle;
    bus0.inst_block_sigs = blk;
  endtask

  task automatic drive1(input logic axis, input logic [4:0] idle, input logic [2:0] blk);
    bus1.axis_block_sigs = axis;
    bus1.inst_idle_sigs  = idle;
    bus1.inst_block_sigs = blk;
  endtask

  initial begin
    // X on inputs under reset must not reach the outputs
    bus0.axis_block_sigs = 'x;
    bus0.inst_idle_sigs  = 'x;
    bus0.inst_block_sigs = 'x;
    drive1(1'b0, 5'b11111, 3'b000);
    tick(2);
    check("rst_block",     {31'd0, bus0.block},         32'd0);
    check("rst_stall",     bus0.stall_cycles,           32'd0);
    check("rst_inst_mask", {29'd0, bus0.blk_inst_mask}, 32'd0);
    check("rst_axis_mask", {31'd0, bus0.blk_axis_mask}, 32'd0);
    check("rst_idx",       {31'd0, bus0.first_blk_idx}, 32'd0);
    check("rst_vld",       {31'd0, bus0.first_blk_vld}, 32'd0);

    // Finished kernel: all idle, nothing blocked
    reset = 1'b0;
    drive0(1'b0, 5'b11111, 3'b000);
    tick(40);
    check("allidle_block", {31'd0, bus0.block}, 32'd0);
    check("allidle_stall", bus0.stall_cycles,   32'd0);

    // 15 candidate cycles then a drop: no block
    drive0(1'b0, 5'b11010, 3'b101);
    tick(15);
    check("c15_block", {31'd0, bus0.block}, 32'd0);
    check("c15_stall", bus0.stall_cycles,   32'd15);
    drive0(1'b0, 5'b00000, 3'b000);
    tick(1);
    check("drop_stall", bus0.stall_cycles,   32'd0);
    tick(5);
    check("drop_block", {31'd0, bus0.block}, 32'd0);

    // 16 candidate cycles: block
    drive0(1'b0, 5'b11010, 3'b101);
    tick(15);
    check("c16_pre_block", {31'd0, bus0.block}, 32'd0);
    tick(1);
    check("c16_block",     {31'd0, bus0.block},         32'd1);
    check("c16_inst_mask", {29'd0, bus0.blk_inst_mask}, 32'h5);
    check("c16_axis_mask", {31'd0, bus0.blk_axis_mask}, 32'd0);
    check("c16_idx",       {31'd0, bus0.first_blk_idx}, 32'd0);
    check("c16_vld",       {31'd0, bus0.first_blk_vld}, 32'd1);
    check("c16_stall",     bus0.stall_cycles,           32'd16);

    // Kernel goes all idle after the detection
    drive0(1'b0, 5'b11111, 3'b000);
    tick(1);
    check("post_stall", bus0.stall_cycles, 32'd0);
`ifdef DEADLOCK_STALL_RELEASE_EN
    check("post_block",     {31'd0, bus0.block},         32'd0);
    check("post_inst_mask", {29'd0, bus0.blk_inst_mask}, 32'h5);
    check("post_vld",       {31'd0, bus0.first_blk_vld}, 32'd1);
`else
    tick(5);
    check("post_block",     {31'd0, bus0.block},         32'd1);
    check("post_inst_mask", {29'd0, bus0.blk_inst_mask}, 32'h5);
`endif

    // Reset pulse clears everything
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rp_block",     {31'd0, bus0.block},         32'd0);
    check("rp_inst_mask", {29'd0, bus0.blk_inst_mask}, 32'd0);
    check("rp_vld",       {31'd0, bus0.first_blk_vld}, 32'd0);

    // Inst0 busy and unblocked: not every instance stalled
    drive0(1'b1, 5'b11110, 3'b000);
    tick(20);
    check("axis_only_block", {31'd0, bus0.block}, 32'd0);
    check("axis_only_stall", bus0.stall_cycles,   32'd0);

    // Inst0 now blocked alongside the AXIS stall
    drive0(1'b1, 5'b11110, 3'b001);
    tick(16);
    check("axis_block",     {31'd0, bus0.block},         32'd1);
    check("axis_axis_mask", {31'd0, bus0.blk_axis_mask}, 32'd1);
    check("axis_inst_mask", {29'd0, bus0.blk_inst_mask}, 32'h1);

    // Interrupted run restarts; lowest blocker is inst1
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    drive0(1'b0, 5'b11001, 3'b110);
    tick(10);
    drive0(1'b0, 5'b11000, 3'b110);
    tick(1);
    drive0(1'b0, 5'b11001, 3'b110);
    tick(15);
    check("restart_block", {31'd0, bus0.block}, 32'd0);
    check("restart_stall", bus0.stall_cycles,   32'd15);
    tick(1);
    check("idx_block",     {31'd0, bus0.block},         32'd1);
    check("idx_idx",       {31'd0, bus0.first_blk_idx}, 32'd1);
    check("idx_inst_mask", {29'd0, bus0.blk_inst_mask}, 32'h6);

    // HOLD_CYCLES=1: reset in the same cycle as cand wins
    drive1(1'b0, 5'b11010, 3'b101);
    tick(1);
    check("h1_rst_block", {31'd0, bus1.block}, 32'd0);
    rst1 = 1'b0;
    drive1(1'b0, 5'b00000, 3'b000);
    tick(1);
    check("h1_idle_block", {31'd0, bus1.block}, 32'd0);
    drive1(1'b0, 5'b11010, 3'b101);
    tick(1);
    check("h1_block",     {31'd0, bus1.block},         32'd1);
    check("h1_stall",     bus1.stall_cycles,           32'd1);
    check("h1_inst_mask", {29'd0, bus1.blk_inst_mask}, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
